// File: rtl/grid_render_pkg.sv
// Shared types and constants for the grid renderer and its colour palette.
package grid_render_pkg;

    localparam int unsigned GRID_ROWS = 22;
    localparam int unsigned GRID_COLS = 10;
    localparam int unsigned COLOR_W   = 3;
    localparam int unsigned RGB_W     = 12;
    localparam int unsigned ROW_W     = $clog2(GRID_ROWS);
    localparam int unsigned COL_W     = $clog2(GRID_COLS);

    typedef logic [RGB_W-1:0] rgb12_t;

    typedef enum logic [COLOR_W-1:0] {
        CL0, CL1, CL2, CL3, CL4, CL5, CL6, CL7
    } color_t;

    typedef logic [GRID_ROWS-1:0][GRID_COLS-1:0][COLOR_W-1:0] grid_t;

    localparam rgb12_t PAL_CL0     = 12'h000;
    localparam rgb12_t PAL_CL1     = 12'h0FF;
    localparam rgb12_t PAL_CL2     = 12'h00F;
    localparam rgb12_t PAL_CL3     = 12'hF80;
    localparam rgb12_t PAL_CL4     = 12'hFF0;
    localparam rgb12_t PAL_CL5     = 12'h0F0;
    localparam rgb12_t PAL_CL6     = 12'hA0F;
    localparam rgb12_t PAL_CL7     = 12'hF00;
    localparam rgb12_t RGB_BLACK   = 12'h000;
    localparam rgb12_t RGB_WHITE   = 12'hFFF;
    localparam rgb12_t RGB_LATTICE = 12'h333;

    typedef enum logic [1:0] {
        REG_BACK,
        REG_BORDER,
        REG_INSIDE
    } region_t;

    typedef enum logic {
        ST_SHOW,
        ST_PENDING
    } snap_state_t;

    // Stage-1 pixel context; row/col are zero unless region is REG_INSIDE.
    typedef struct packed {
        region_t          region;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
        logic             de;
        logic             hs;
        logic             vs;
    } s1_t;

endpackage

// File: rtl/grid_render_color_palette.sv
// Combinational colour-code to 12-bit RGB lookup, shared by any grid-style display.
module color_palette
    import grid_render_pkg::*;
(
    input  color_t code_i,
    output rgb12_t rgb_c_o
);

    always_comb begin
        rgb_c_o = RGB_BLACK;
        unique case (code_i)
            CL0:     rgb_c_o = PAL_CL0;
            CL1:     rgb_c_o = PAL_CL1;
            CL2:     rgb_c_o = PAL_CL2;
            CL3:     rgb_c_o = PAL_CL3;
            CL4:     rgb_c_o = PAL_CL4;
            CL5:     rgb_c_o = PAL_CL5;
            CL6:     rgb_c_o = PAL_CL6;
            CL7:     rgb_c_o = PAL_CL7;
            default: rgb_c_o = RGB_BLACK;
        endcase
    end

endmodule

// File: rtl/grid_render.sv
// Game-grid to RGB renderer: tear-free shadow snapshot FSM plus a 2-stage pixel pipeline.
// Optional empty-cell lattice enabled by defining GRID_RENDER_GRIDLINES_EN.
module grid_render
    import grid_render_pkg::*;
#(
    parameter int unsigned CELL_LOG2 = 4,
    parameter int unsigned BOARD_X0  = 240,
    parameter int unsigned BOARD_Y0  = 80,
    parameter int unsigned FIRST_ROW = 1,
    parameter int unsigned BORDER_PX = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  grid_t      grid,
    input  logic       grid_stable,
    input  logic       frame_start,
    input  logic [9:0] px_x,
    input  logic [9:0] px_y,
    input  logic       de_i,
    input  logic       hs_i,
    input  logic       vs_i,
    output rgb12_t     rgb,
    output logic       de_o,
    output logic       hs_o,
    output logic       vs_o,
    output logic       snap_ack,
    output logic       snap_miss
);

    localparam int unsigned PX_W     = 10;
    localparam int unsigned CRD_W    = PX_W + 1;
    localparam int unsigned VIS_ROWS = GRID_ROWS - 1 - FIRST_ROW;

    localparam logic signed [CRD_W-1:0] ZERO  = '0;
    localparam logic signed [CRD_W-1:0] X0    = CRD_W'(BOARD_X0);
    localparam logic signed [CRD_W-1:0] Y0    = CRD_W'(BOARD_Y0);
    localparam logic signed [CRD_W-1:0] INT_W = CRD_W'(GRID_COLS << CELL_LOG2);
    localparam logic signed [CRD_W-1:0] INT_H = CRD_W'(VIS_ROWS << CELL_LOG2);
    localparam logic signed [CRD_W-1:0] BRD   = CRD_W'(BORDER_PX);

    // Snapshot FSM
    snap_state_t state_q, state_d;
    logic        ack_q, ack_d;
    logic        miss_q, miss_d;
    grid_t       shadow_q;

    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        miss_d  = 1'b0;
        unique case (state_q)
            ST_SHOW: begin
                if (frame_start) begin
                    if (grid_stable && !de_i) ack_d = 1'b1;
                    else state_d = ST_PENDING;
                end
            end
            ST_PENDING: begin
                // Active video wins over a late grid_stable so a frame never mixes snapshots.
                if (de_i) begin
                    miss_d  = 1'b1;
                    state_d = ST_SHOW;
                end else if (grid_stable) begin
                    ack_d   = 1'b1;
                    state_d = ST_SHOW;
                end
            end
            default: state_d = ST_SHOW;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_SHOW;
            ack_q    <= 1'b0;
            miss_q   <= 1'b0;
            shadow_q <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            miss_q  <= miss_d;
            if (ack_d) shadow_q <= grid;
        end
    end

    // Stage 1: board-relative coordinates and region classification
    logic signed [CRD_W-1:0] dx, dy;
    logic                    in_x, in_y, near_x, near_y;
    s1_t                     s1_d, s1_q;

    always_comb begin
        dx     = $signed({1'b0, px_x}) - X0;
        dy     = $signed({1'b0, px_y}) - Y0;
        in_x   = (dx >= ZERO) && (dx < INT_W);
        in_y   = (dy >= ZERO) && (dy < INT_H);
        near_x = (dx >= -BRD) && (dx < INT_W + BRD);
        near_y = (dy >= -BRD) && (dy < INT_H + BRD);

        s1_d        = '0;
        s1_d.de     = de_i;
        s1_d.hs     = hs_i;
        s1_d.vs     = vs_i;
        s1_d.region = REG_BACK;
        if (in_x && in_y) begin
            s1_d.region = REG_INSIDE;
            s1_d.col    = COL_W'(dx >>> CELL_LOG2);
            s1_d.row    = ROW_W'(dy >>> CELL_LOG2) + ROW_W'(FIRST_ROW);
        end else if (near_x && near_y) begin
            s1_d.region = REG_BORDER;
        end
    end

`ifdef GRID_RENDER_GRIDLINES_EN
    logic line_d, line_q;
    assign line_d = (dx[CELL_LOG2-1:0] == '0) || (dy[CELL_LOG2-1:0] == '0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
`ifdef GRID_RENDER_GRIDLINES_EN
            line_q <= 1'b0;
`endif
        end else begin
            s1_q <= s1_d;
`ifdef GRID_RENDER_GRIDLINES_EN
            line_q <= line_d;
`endif
        end
    end

    // Stage 2: shadow lookup (indices are zero outside the board) and colour select
    color_t cell_code;
    rgb12_t pal_rgb;
    rgb12_t rgb_q, rgb_d;
    logic   de_q, hs_q, vs_q;

    assign cell_code = color_t'(shadow_q[s1_q.row][s1_q.col]);

    color_palette u_palette (
        .code_i  (cell_code),
        .rgb_c_o (pal_rgb)
    );

    always_comb begin
        rgb_d = RGB_BLACK;
        unique case (s1_q.region)
            REG_INSIDE: begin
                rgb_d = pal_rgb;
`ifdef GRID_RENDER_GRIDLINES_EN
                if (line_q && (cell_code == CL0)) rgb_d = RGB_LATTICE;
`endif
            end
            REG_BORDER: rgb_d = RGB_WHITE;
            default:    rgb_d = RGB_BLACK;
        endcase
        if (!s1_q.de) rgb_d = RGB_BLACK;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q <= RGB_BLACK;
            de_q  <= 1'b0;
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
        end else begin
            rgb_q <= rgb_d;
            de_q  <= s1_q.de;
            hs_q  <= s1_q.hs;
            vs_q  <= s1_q.vs;
        end
    end

    assign rgb       = rgb_q;
    assign de_o      = de_q;
    assign hs_o      = hs_q;
    assign vs_o      = vs_q;
    assign snap_ack  = ack_q;
    assign snap_miss = miss_q;

endmodule

// File: tb/tb_grid_render.sv
// Randomised scoreboard bench for grid_render; model follows the pixel/snapshot rules directly.
module tb_grid_render;
    import grid_render_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    grid_t      grid;
    logic       grid_stable, frame_start;
    logic [9:0] px_x, px_y;
    logic       de_i, hs_i, vs_i;
    rgb12_t     rgb;
    logic       de_o, hs_o, vs_o, snap_ack, snap_miss;

    grid_render dut (
        .clk         (clk),
        .rst         (rst),
        .grid        (grid),
        .grid_stable (grid_stable),
        .frame_start (frame_start),
        .px_x        (px_x),
        .px_y        (px_y),
        .de_i        (de_i),
        .hs_i        (hs_i),
        .vs_i        (vs_i),
        .rgb         (rgb),
        .de_o        (de_o),
        .hs_o        (hs_o),
        .vs_o        (vs_o),
        .snap_ack    (snap_ack),
        .snap_miss   (snap_miss)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] rgb;
        logic        de;
        logic        hs;
        logic        vs;
    } px_exp_t;

    localparam logic [11:0] PAL_REF [8] = '{12'h000, 12'h0FF, 12'h00F, 12'hF80,
                                            12'hFF0, 12'h0F0, 12'hA0F, 12'hF00};

    px_exp_t    pq[$];
    logic [1:0] eq[$];
    int         sh [22][10];
    bit         pending;
    int         total = 0;
    int         bad   = 0;

    // Reference pixel: board is 10x20 cells of 16px at (240,80), shown rows 1..20, 4px frame.
    function automatic px_exp_t ref_pixel(int x, int y, logic de, logic hs, logic vs);
        int dx = x - 240;
        int dy = y - 80;
        int code;
        logic [11:0] c = 12'h000;
        if (dx >= 0 && dx < 160 && dy >= 0 && dy < 320) begin
            code = sh[dy / 16 + 1][dx / 16];
            c = PAL_REF[code];
`ifdef GRID_RENDER_GRIDLINES_EN
            if (code == 0 && (dx % 16 == 0 || dy % 16 == 0)) c = 12'h333;
`endif
        end else if (dx >= -4 && dx < 164 && dy >= -4 && dy < 324) begin
            c = 12'hFFF;
        end
        if (!de) c = 12'h000;
        return '{rgb: c, de: de, hs: hs, vs: vs};
    endfunction

    task automatic step(input logic r, input int x, input int y, input logic de,
                        input logic hs, input logic vs, input logic fs, input logic stb);
        logic ack, miss;
        @(negedge clk);
        rst = r; px_x = 10'(x); px_y = 10'(y); de_i = de; hs_i = hs; vs_i = vs;
        frame_start = fs; grid_stable = stb;
        if (r) begin
            foreach (sh[i, j]) sh[i][j] = 0;
            pending = 1'b0;
            // Reset flushes both pipeline stages, so the in-flight pixel is also black.
            if (pq.size() > 0) pq[pq.size() - 1] = '0;
            pq.push_back('0);
            eq.push_back(2'b00);
        end else begin
            ack = 1'b0; miss = 1'b0;
            if (!pending) begin
                if (fs) begin
                    if (stb && !de) ack = 1'b1;
                    else pending = 1'b1;
                end
            end else if (de) begin
                miss = 1'b1; pending = 1'b0;
            end else if (stb) begin
                ack = 1'b1; pending = 1'b0;
            end
            if (ack) foreach (sh[i, j]) sh[i][j] = int'(grid[i][j]);
            pq.push_back(ref_pixel(x, y, de, hs, vs));
            eq.push_back({ack, miss});
        end
    endtask

    task automatic blank(input int n, input logic stb);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, stb);
    endtask

    task automatic rand_pixels(input int n, input logic stb);
        int x, y;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(7) == 0) begin
                x = $urandom_range(1023); y = $urandom_range(1023);
            end else begin
                x = $urandom_range(230, 410); y = $urandom_range(70, 410);
            end
            step(1'b0, x, y, ($urandom_range(9) != 0), 1'($urandom), 1'b0, 1'b0, stb);
        end
    endtask

    task automatic rand_grid();
        for (int r = 0; r < 22; r++)
            for (int c = 0; c < 10; c++)
                grid[r][c] = ($urandom_range(2) == 0) ? 3'd0 : 3'($urandom_range(7));
    endtask

    // Monitor: pixel outputs lag stimulus by two edges, snapshot pulses by one.
    always @(posedge clk) begin
        px_exp_t    e;
        logic [1:0] s;
        #1;
        if (pq.size() >= 2) begin
            e = pq.pop_front();
            total++;
            if ({rgb, de_o, hs_o, vs_o} !== e) begin
                bad++;
                $display("FAIL pixel: got rgb=%h de=%b hs=%b vs=%b, expected rgb=%h de=%b hs=%b vs=%b",
                         rgb, de_o, hs_o, vs_o, e.rgb, e.de, e.hs, e.vs);
            end
        end
        if (eq.size() >= 1) begin
            s = eq.pop_front();
            total++;
            if ({snap_ack, snap_miss} !== s) begin
                bad++;
                $display("FAIL snap: got ack=%b miss=%b, expected ack=%b miss=%b",
                         snap_ack, snap_miss, s[1], s[0]);
            end
        end
    end

    initial begin
        rst = 1'b1; grid = '0; grid_stable = 1'b0; frame_start = 1'b0;
        px_x = '0; px_y = '0; de_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
        pending = 1'b0;
        foreach (sh[i, j]) sh[i][j] = 0;

        repeat (3) step(1'b1, 300, 100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Load a random grid, show it, then reset mid-frame with active video.
        rand_grid();
        step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        rand_pixels(40, 1'b1);
        step(1'b1, 288, 144, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 300, 200, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++)
            step(1'b0, 240 + 8 * i, 80 + 16 * i, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Single occupied cell at grid[5][3], loaded with a stable grid.
        grid = '0;
        grid[5][3] = 3'd4;
        step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 288, 144, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 303, 159, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 288, 144, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Writer busy at frame start, stable 10 cycles later during blanking.
        rand_grid();
        step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        blank(9, 1'b0);
        blank(3, 1'b1);
        rand_pixels(60, 1'b1);

        // Writer busy through to active video: snapshot abandoned, old shadow kept.
        rand_grid();
        step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        blank(5, 1'b0);
        step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        blank(3, 1'b0);
        rand_pixels(80, 1'b1);

        // Region boundaries and lattice probe points.
        grid = '0;
        grid[2][1] = 3'd6;
        step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 238, 100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 404, 100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 410, 100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 235, 100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 300, 76, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 300, 403, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 300, 404, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 256, 96, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 257, 97, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 256, 96 + 16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 399, 399, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Random frames with random writer timing.
        for (int f = 0; f < 40; f++) begin
            logic stb0;
            rand_grid();
            stb0 = 1'($urandom_range(1));
            step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, stb0);
            blank($urandom_range(1, 15), 1'($urandom_range(3) == 0));
            rand_pixels(150, 1'($urandom));
        end

        blank(3, 1'b0);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
